dma_mem_arb: RTL

Two-port memory arbiter that sits between the CPU data port and the `dma_engine` master port (`dma_mem_*`). It is the responder for both requesters and drives a single downstream memory port using the same req/ready protocol. The CPU has default priority, and a starvation counter guarantees DMA forward progress. A transaction that has been issued downstream stays locked to its owner until it completes.

---
 rtl/dma_mem_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dma_mem_arb.sv
// rtl/dma_mem_arb.sv - CPU/DMA two-port memory arbiter with starvation guard and transaction lock
module dma_mem_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int XLEN         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mem_req,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [XLEN-1:0]   cpu_mem_wdata,
    output logic [XLEN-1:0]   cpu_mem_rdata,
    output logic              cpu_mem_ready,
    input  logic              dma_mem_req,
    input  logic              dma_mem_we,
    input  logic [ADDR_W-1:0] dma_mem_addr,
    input  logic [XLEN-1:0]   dma_mem_wdata,
    output logic [XLEN-1:0]   dma_mem_rdata,
    output logic              dma_mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              arb_dma_sel
);

    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_UNLOCKED   = 2'd0,
        S_LOCKED_CPU = 2'd1,
        S_LOCKED_DMA = 2'd2
    } lock_state_t;

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic        r_active;
    logic [7:0]  r_starve_cnt;

    logic        w_lock;
    logic        w_lock_dma;
    logic        w_sel_valid;
    logic        w_sel_dma;
    logic        w_mem_req;
    logic        w_cpu_hs;
    logic        w_dma_hs;

    assign w_lock     = (r_state != S_UNLOCKED);
    assign w_lock_dma = (r_state == S_LOCKED_DMA);

    // Nothing is selected until the first clock after reset, so a request
    // pending across reset is never forwarded in the reset-release cycle.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_dma   = 1'b0;
        if (r_active) begin
            if (w_lock) begin
                w_sel_valid = 1'b1;
                w_sel_dma   = w_lock_dma;
            end else if (dma_mem_req && (!cpu_mem_req || (r_starve_cnt >= LP_LIMIT))) begin
                w_sel_valid = 1'b1;
                w_sel_dma   = 1'b1;
            end else if (cpu_mem_req) begin
                w_sel_valid = 1'b1;
                w_sel_dma   = 1'b0;
            end
        end
    end

    assign w_mem_req = w_sel_valid && (w_sel_dma ? dma_mem_req : cpu_mem_req);
    assign w_cpu_hs  = mem_ready && w_mem_req && !w_sel_dma;
    assign w_dma_hs  = mem_ready && w_mem_req && w_sel_dma;

    assign mem_req       = w_mem_req;
    assign mem_we        = w_sel_valid ? (w_sel_dma ? dma_mem_we    : cpu_mem_we)    : 1'b0;
    assign mem_addr      = w_sel_valid ? (w_sel_dma ? dma_mem_addr  : cpu_mem_addr)  : '0;
    assign mem_wdata     = w_sel_valid ? (w_sel_dma ? dma_mem_wdata : cpu_mem_wdata) : '0;
    assign cpu_mem_ready = w_cpu_hs;
    assign dma_mem_ready = w_dma_hs;
    assign cpu_mem_rdata = mem_rdata;
    assign dma_mem_rdata = mem_rdata;
    assign arb_dma_sel   = w_sel_valid && w_sel_dma;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNLOCKED: begin
                if (w_mem_req && !mem_ready) begin
                    w_state_nxt = w_sel_dma ? S_LOCKED_DMA : S_LOCKED_CPU;
                end
            end
            S_LOCKED_CPU: begin
                if (w_cpu_hs) begin
                    w_state_nxt = S_UNLOCKED;
                end
            end
            S_LOCKED_DMA: begin
                if (w_dma_hs) begin
                    w_state_nxt = S_UNLOCKED;
                end
            end
            default: w_state_nxt = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_UNLOCKED;
            r_active <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_active <= 1'b1;
        end
    end

    // A stalled DMA transfer that is already selected does not count as starved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 8'd0;
        end else if (w_dma_hs) begin
            r_starve_cnt <= 8'd0;
        end else if (dma_mem_req && !(w_mem_req && w_sel_dma) && (r_starve_cnt != 8'hFF)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

endmodule
